// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with optional radix-2 Booth signed mode.
// Operands and results are exchanged over valid/ready handshakes.
module seq_multiplier #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  input  logic                 signed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   a_q, m_q, sum_d, a_d, m_ext_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, mode_q, mode_d;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;

  assign mode_d  = signed_i & SIGNED_EN;
  assign m_ext_d = {mode_d & multiplicand_i[WIDTH-1], multiplicand_i};

  // One add/subtract followed by a right shift of {A,Q}; A's extra bit
  // keeps the unsigned carry and the Booth sign from being lost.
  always_comb begin
    sum_d = a_q;
    if (mode_q) begin
      case ({q_q[0], q1_q})
        2'b01:   sum_d = a_q + m_q;
        2'b10:   sum_d = a_q - m_q;
        default: sum_d = a_q;
      endcase
    end else if (q_q[0]) begin
      sum_d = a_q + m_q;
    end
    a_d = {mode_q & sum_d[WIDTH], sum_d[WIDTH:1]};
    q_d = {sum_d[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      m_q         <= '0;
      q_q         <= '0;
      q1_q        <= 1'b0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_q        <= '0;
            q_q        <= multiplier_i;
            m_q        <= m_ext_d;
            q1_q       <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= mode_d;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign product_o   = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: 8-bit signed-capable instance plus a
// 4-bit unsigned-only instance.
module tb_seq_multiplier;
  localparam int W  = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, signed_in = 1'b0;
  logic         out_valid, out_ready = 1'b1, busy;
  logic [W-1:0] mcand = '0, mplier = '0;
  logic [2*W-1:0] product;

  logic          in_valid4 = 1'b0, in_ready4, signed4 = 1'b0;
  logic          out_valid4, out_ready4 = 1'b1, busy4;
  logic [W4-1:0] mcand4 = '0, mplier4 = '0;
  logic [2*W4-1:0] product4;

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .multiplicand_i(mcand), .multiplier_i(mplier), .signed_i(signed_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .product_o(product),
    .busy_o(busy));

  seq_multiplier #(.WIDTH(W4), .SIGNED_EN(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .multiplicand_i(mcand4), .multiplier_i(mplier4), .signed_i(signed4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4), .product_o(product4),
    .busy_o(busy4));

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    acc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit s);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return (2*W)'(x * y);
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    mcand = a; mplier = b; signed_in = s; in_valid = 1'b1;
    sb.push_back('{ref_mul(a, b, s), cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mcand = W'($urandom); mplier = W'($urandom); signed_in = 1'($urandom);
    @(negedge clk);
    check("in_ready_run", in_ready, 0);
    check("busy_run", busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic run4(input logic [W4-1:0] a, input logic [W4-1:0] b, input bit s);
    int n = 0;
    logic [2*W4-1:0] exp4;
    exp4 = (2*W4)'(int'(a) * int'(b));
    @(negedge clk);
    check("w4_in_ready", in_ready4, 1);
    mcand4 = a; mplier4 = b; signed4 = s; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("w4_in_ready_run", in_ready4, 0);
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4_latency", n, W4);
    check("w4_product", product4, exp4);
    @(negedge clk);
    check("w4_out_valid_clr", out_valid4, 0);
  endtask

  exp_t        mon_e;
  logic [2*W-1:0] cur = '0;
  bit          seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_out", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          cur = mon_e.prod;
          check("product", product, mon_e.prod);
          check("latency", cyc - mon_e.acc - 1, W);
        end
      end else begin
        check("product_hold", product, cur);
      end
      check("in_ready_done", in_ready, 0);
      check("busy_done", busy, 1);
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_product4", product4, 0);
    rst_n = 1'b1;

    // Unsigned-only build: Signed=1 must be ignored
    run4(4'd13, 4'd11, 1'b1);
    run4(4'hF, 4'h2, 1'b1);
    run4(4'h0, 4'h9, 1'b0);

    issue(8'hFF, 8'hFF, 1'b0);
    issue(8'h00, 8'h77, 1'b0);
    issue(8'hF9, 8'h05, 1'b1);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'h7F, 8'h80, 1'b1);
    issue(8'hF9, 8'h05, 1'b0);
    drain();

    // Back-pressure with an ignored request during DONE
    out_ready = 1'b0;
    issue(8'hA5, 8'h3C, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        mcand = 8'd3; mplier = 8'd3; signed_in = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      check("bp_busy", busy, 1);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);
    issue(8'd3, 8'd3, 1'b0);
    drain();

    // Reset in the middle of a run
    issue(8'hC3, 8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd6, 8'd7, 1'b0);
    drain();

    for (int k = 0; k < 40; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's 4-bit multiplier datapath.
- Adds a WIDTH parameter, a runtime signed mode (radix-2 Booth recoding), a valid/ready handshake on input and output, and a held result register that tolerates back-pressure.
- Sits between an operand source and a result consumer. Both ends use valid/ready.
- One iteration per clock. The controller is internal; there is no separate control module.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; Product is 2*WIDTH bits.
- SIGNED_EN, 1, when 1 the Signed input selects the mode; when 0 Signed is ignored and all operations are unsigned.

Ports:
- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted at 0).
- In_Valid  input  1  operand pair valid.
- In_Ready  output  1  block can accept operands.
- Multiplicand  input  WIDTH  operand M.
- Multiplier  input  WIDTH  operand Q.
- Signed  input  1  1 = two's-complement operands (Booth); 0 = unsigned; sampled at accept.
- Out_Valid  output  1  Product valid.
- Out_Ready  input  1  consumer accepts Product.
- Product  output  2*WIDTH  result, {A[WIDTH-1:0], Q}.
- Busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - state = IDLE, In_Ready = 1, Out_Valid = 0, Busy = 0.
  - A, Q, M, Q_1, count and mode register all 0, so Product = 0.
- Internal registers:
  - A is WIDTH+1 bits.
  - M is WIDTH+1 bits: sign-extended when signed, zero-extended when unsigned.
  - Q is WIDTH bits.
  - Q_1 is 1 bit.
  - count is $clog2(WIDTH) bits.
  - A 1-bit mode register holds the sampled Signed value.
- IDLE:
  - In_Ready = 1.
  - Accept occurs on a rising edge with In_Valid=1.
  - On accept: A←0, Q←Multiplier, M←extended Multiplicand, Q_1←0, count←0, mode←(Signed & SIGNED_EN), state→RUN.
- RUN (In_Ready = 0), one iteration per edge:
  - Unsigned: if Q[0], A←A+M. Then logical right shift of {A,Q} by one.
  - Signed: recode on {Q[0],Q_1}:
    - 01: A←A+M.
    - 10: A←A−M.
    - 00 or 11: no add.
    - Then arithmetic right shift of {A,Q,Q_1} by one; A's MSB is replicated.
  - Add and shift are computed combinationally and registered in the same edge.
  - count increments each iteration. On the edge where count == WIDTH−1, state→DONE.
- Latency:
  - Exactly WIDTH cycles from the accept edge to the edge that sets Out_Valid.
  - Data-independent; no early termination, including zero operands.
- DONE:
  - Out_Valid = 1. Product, A and Q are frozen.
  - On an edge with Out_Ready=1: state→IDLE and Out_Valid→0. In_Ready becomes 1 the following cycle; no same-cycle turnaround.
  - Out_Ready=0 holds DONE indefinitely with Product stable.
- Product:
  - Always driven as {A[WIDTH-1:0], Q}.
  - Meaningful only while Out_Valid=1.
  - After return to IDLE it holds the last result until the next accept.
- Width rules:
  - A's extra bit absorbs the unsigned carry and the Booth sign.
  - −2^(WIDTH−1) × −2^(WIDTH−1) must produce +2^(2·WIDTH−2) without overflow.
- Operand inputs and Signed are ignored outside IDLE. In_Valid asserted during RUN/DONE is not accepted and not queued.
- Out_Ready outside DONE has no effect.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. No partial result is presented.

Test Plan:
- WIDTH=4, unsigned, 13×11 → Out_Valid exactly 4 cycles after accept; Product=8'h8F (143); In_Ready=0 during RUN/DONE.
- WIDTH=8, unsigned, 255×255 → Product=16'hFE01; latency 8 cycles. Then 0×77 → Product=16'h0000, latency still 8.
- WIDTH=8, signed:
  - −7×5 → Product=16'hFFDD (−35).
  - −128×−128 → 16'h4000.
  - 127×−128 → 16'hC080.
  - Same −7 (8'hF9) × 5 with Signed=0 → 16'h04DD (1245).
- Back-pressure: hold Out_Ready=0 for 6 cycles after Out_Valid → Product stable, Busy=1, and a new In_Valid with 3×3 during DONE is ignored. Out_Ready=1 → IDLE; the next accepted 3×3 yields 9.
- Reset: assert Reset=0 at iteration 3 of a WIDTH=8 run → all outputs immediately at reset values (In_Ready=1, Out_Valid=0, Product=0). A fresh 6×7 after release → 42.
- SIGNED_EN=0 build: Signed=1 with 8'hFF×8'h02 → unsigned Product=16'h01FE.
